audio_frame_prep: RTL
=====================

# audio_frame_prep

Upstream stage of `sig_core`. It takes a free-running 16-bit ADC sample stream, optionally applies a first-order pre-emphasis filter, and stores samples in a circular buffer. It emits overlapping frames of FRAME_LEN samples, one frame every HOP new samples, on the `audio_data`/`audio_valid`/`audio_rdy` handshake that `sig_core` consumes.

## Interface
- FRAME_LEN, 512: samples per emitted frame.
- HOP, 256: new samples between successive frame starts; 1 ≤ HOP ≤ FRAME_LEN.
- DEPTH, 1024: buffer depth; power of two, > FRAME_LEN.
- AW, 10: log2(DEPTH).

Ports:
- clk  in  1  sole clock; everything on posedge.
- rst  in  1  synchronous, active-low reset.
- init  in  1  synchronous framing restart; same effect as reset, sampled high.
- adc_data  in  16  signed sample.
- adc_valid  in  1  one-cycle strobe, no backpressure.
- audio_data  out  16  frame sample to `sig_core`.
- audio_valid  out  1  `audio_data` valid.
- audio_rdy  in  1  consumer accepts when high together with `audio_valid`.
- overrun  out  1  sticky: a sample was dropped.

## Operation
- State: `wr_ptr` (AW+1 bits), `base` (AW+1), `idx` (frame word index), `x_prev` (16), FSM {FILL, FETCH, SEND}.
- `pending = wr_ptr - base`, modulo 2^(AW+1).
- Write path is independent of the FSM. On `adc_valid`:
  - If `pending < DEPTH`, write the processed sample to `mem[wr_ptr[AW-1:0]]` and increment `wr_ptr`.
  - Otherwise drop the sample and set `overrun`.
  - `x_prev` updates to the raw `adc_data` in both cases.
- FSM:
  - FILL: when `pending ≥ FRAME_LEN`, set `idx = 0` and go to FETCH.
  - FETCH: read `mem[(base+idx)[AW-1:0]]` into the output register, then go to SEND.
  - SEND: hold `audio_valid = 1`. On `audio_rdy`:
    - If `idx == FRAME_LEN-1`: `base += HOP`, go to FILL.
    - Else: `idx++`, go to FETCH.
- Frame order is oldest to newest. Writes during FETCH/SEND never corrupt the frame being sent, because `pending ≤ DEPTH` and `base` is frozen until the frame completes.
- Frame k (from 0) carries buffered samples k·HOP … k·HOP+FRAME_LEN-1.

## Timing
- Reset/init values: `audio_valid` 0, `audio_data` 0, `overrun` 0, FSM FILL, all pointers 0, `x_prev` 0. Memory contents are don't-care.
- `rst` has priority over `init`, and `init` has priority over `adc_valid` in the same cycle; the sample in that cycle is discarded.
- Reset or init mid-frame: `audio_valid` is 0 from the next cycle, and the partial frame is abandoned.
- Latency: the sample that makes `pending == FRAME_LEN` is written at edge N. FSM enters FETCH at N+1, and `audio_valid` rises after edge N+2.
- Throughput: at most one word per 2 cycles, because FETCH is inserted between words.
- Handshake: while `audio_valid` is high and `audio_rdy` is low, `audio_data` must be held stable. `audio_valid` never drops without an acceptance, except on rst/init.
- Simultaneous write and read of the same address cannot occur.
- Back-to-back frames: if `pending ≥ FRAME_LEN` still holds after `base += HOP`, FILL moves to FETCH on the next cycle.
- Pointer wrap-around is natural (AW+1-bit arithmetic). No special handling is required.

## Configuration
- `AUDIO_PREEMPH_EN` defined: stored sample is `y = x - x_prev + (x_prev >>> 5)`, i.e. x − (31/32)·x_prev.
  - Computed in 18-bit signed and saturated to [-32768, 32767].
  - The first sample after reset/init uses `x_prev = 0`.
- `AUDIO_PREEMPH_EN` undefined: `y = x` (pass-through). `x_prev` logic is removed.

## Test plan
- Ramp `adc_data` 0..511, `audio_rdy` = 1, no PREEMPH -> one frame 0..511 in order, one word every 2 cycles, first `audio_valid` 2 cycles after the 512th write.
- Continue ramp 512..767 -> second frame 256..767. Frame 2 does not start before sample 767 is written.
- PREEMPH on, constant input 1024 ×512 -> first word 1024, remaining 511 words 32.
- PREEMPH on, inputs -32768 then 32767 -> second word saturates to 32767. Inputs 32767 then -32768 -> second word saturates to -32768.
- `audio_rdy` low 10 cycles mid-frame -> `audio_valid` and `audio_data` constant throughout. Then `rst` low for 1 cycle -> `audio_valid` 0, and the next frame needs 512 fresh samples.
- `audio_rdy` held 0, feed 1025 samples -> `overrun` rises on the 1025th sample and stays set. Then `audio_rdy` = 1 -> frame 0..511 is intact, and the next frame is 256..767 (sample 1024 absent).

Source files
------------

// File: rtl/audio_frame_prep.sv
// audio_frame_prep: buffers a free-running 16-bit ADC stream in a circular RAM and emits
// overlapping FRAME_LEN-sample frames every HOP samples. Define AUDIO_PREEMPH_EN for pre-emphasis.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FILL  | waiting until FRAME_LEN unsent samples are buffered past base
// S_FETCH | reading word base+idx from the buffer into the output register
// S_SEND  | audio_valid held high until the consumer accepts the word
module audio_frame_prep #(
    parameter int FRAME_LEN = 512,
    parameter int HOP       = 256,
    parameter int DEPTH     = 1024,
    parameter int AW        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    output logic [15:0] audio_data,
    output logic        audio_valid,
    input  logic        audio_rdy,
    output logic        overrun
);

    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   FRAME_W   = (AW + 1)'(FRAME_LEN);
    localparam logic [AW:0]   HOP_W     = (AW + 1)'(HOP);
    localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_FETCH,
        S_SEND
    } state_t;

    state_t      r_state;
    logic [15:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_base;
    logic [IW-1:0] r_idx;

    logic          w_clear;
    logic [AW:0]   w_pending;
    logic          w_room;
    logic [AW-1:0] w_rd_addr;
    logic [15:0]   w_sample;

    assign w_clear   = !rst || init;
    assign w_pending = r_wr_ptr - r_base;
    assign w_room    = w_pending < DEPTH_W;
    assign w_rd_addr = r_base[AW-1:0] + AW'(r_idx);

`ifdef AUDIO_PREEMPH_EN
    logic signed [15:0] r_x_prev;
    logic signed [15:0] w_xp_shr;
    logic signed [17:0] w_pre;

    // y = x - x_prev + (x_prev >>> 5); 18 bits cannot overflow before saturation
    assign w_xp_shr = r_x_prev >>> 5;
    assign w_pre    = {{2{adc_data[15]}}, adc_data}
                    - {{2{r_x_prev[15]}}, r_x_prev}
                    + {{2{w_xp_shr[15]}}, w_xp_shr};

    always_comb begin
        w_sample = w_pre[15:0];
        if (w_pre[17:15] != 3'b000 && w_pre[17:15] != 3'b111) begin
            w_sample = w_pre[17] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_x_prev <= '0;
        end else if (adc_valid) begin
            r_x_prev <= adc_data;
        end
    end
`else
    assign w_sample = adc_data;
`endif

    always_ff @(posedge clk) begin
        if (!w_clear && adc_valid && w_room) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            overrun  <= 1'b0;
        end else if (adc_valid) begin
            if (w_room) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    // base only moves after a whole frame, so words of the frame in flight are never overwritten
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state     <= S_FILL;
            r_idx       <= '0;
            r_base      <= '0;
            audio_data  <= '0;
            audio_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_pending >= FRAME_W) begin
                        r_idx   <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    audio_data  <= r_mem[w_rd_addr];
                    audio_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (audio_rdy) begin
                        audio_valid <= 1'b0;
                        if (r_idx == IDX_LAST) begin
                            r_base  <= r_base + HOP_W;
                            r_state <= S_FILL;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule
